// File: rtl/antiglitch_cfg_seq.sv
// antiglitch_cfg_seq: AXI4-Lite master that writes a bank of configuration
// registers in the antiglitch slave, reads each one back and compares it.
// A register that fails is retried a bounded number of times before the
// sequence aborts with an error index and code.
// Build option: define ANTIGLITCH_CFG_READBACK_EN to include the readback and
// compare stages. Without it, only writes are issued and only BRESP is checked.
module antiglitch_cfg_seq #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int NUM_REGS  = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            start,
    input  logic [NUM_REGS*32-1:0]          cfg_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [3:0]                      err_index,
    output logic [1:0]                      err_code,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR, S_WRESP,
`ifdef ANTIGLITCH_CFG_READBACK_EN
        S_RADDR, S_RDATA, S_CHECK,
`endif
        S_NEXT, S_DONE, S_ERR
    } state_t;

    // The latch array always has 16 entries so a 4-bit index addresses it exactly.
    localparam int PAD_W = 16 * 32;

    state_t       state_reg, state_next;
    logic [3:0]   idx_reg, idx_next;
    logic [2:0]   retry_reg, retry_next;
    logic         fail;
    logic [1:0]   fail_code;
    logic         start_accept, wr_entry, aw_hs, w_hs;
    logic         aw_done_reg, w_done_reg;
    logic         awvalid_reg, wvalid_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_reg;
    logic [31:0]  wdata_reg;
    logic [3:0]   err_index_reg;
    logic [1:0]   err_code_reg;
    logic [PAD_W-1:0] cfg_pad;
    logic [31:0]  cfg_mem [16];

    assign cfg_pad      = PAD_W'(cfg_data);
    assign start_accept = start && (state_reg inside {S_IDLE, S_DONE, S_ERR});
    assign aw_hs        = awvalid_reg && M_AXI_AWREADY;
    assign w_hs         = wvalid_reg && M_AXI_WREADY;
    assign wr_entry     = (state_next == S_WR) && (state_reg != S_WR);

`ifdef ANTIGLITCH_CFG_READBACK_EN
    logic         arvalid_reg;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_reg;
    logic [31:0]  rdata_reg;
`else
    // Read channel inputs have no consumer when readback is not built.
    logic unused_read_inputs;
    assign unused_read_inputs = ^{M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, M_AXI_ARREADY};
`endif

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state, index/retry bookkeeping and failure detection.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        retry_next = retry_reg;
        fail       = 1'b0;
        fail_code  = 2'b00;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_WR;
                    idx_next   = 4'd0;
                    retry_next = 3'd0;
                end
            end
            S_WR: begin
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = S_WRESP;
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end else begin
`ifdef ANTIGLITCH_CFG_READBACK_EN
                        state_next = S_RADDR;
`else
                        state_next = S_NEXT;
`endif
                    end
                end
            end
`ifdef ANTIGLITCH_CFG_READBACK_EN
            S_RADDR: begin
                if (arvalid_reg && M_AXI_ARREADY) state_next = S_RDATA;
            end
            S_RDATA: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end else begin
                        state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rdata_reg == cfg_mem[idx_reg]) begin
                    state_next = S_NEXT;
                end else begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end
            end
`endif
            S_NEXT: begin
                idx_next   = idx_reg + 4'd1;
                retry_next = 3'd0;
                state_next = (idx_reg == 4'(NUM_REGS - 1)) ? S_DONE : S_WR;
            end
            default: state_next = S_IDLE;
        endcase
        // A failed attempt either retries the same register or aborts.
        if (fail) begin
            if (retry_reg < 3'(MAX_RETRY)) begin
                retry_next = retry_reg + 3'd1;
                state_next = S_WR;
            end else begin
                state_next = S_ERR;
            end
        end
    end

    // Latch the configuration words when a sequence is accepted (no reset needed).
    always_ff @(posedge ACLK) begin
        if (start_accept) begin
            for (int i = 0; i < 16; i++) cfg_mem[i] <= cfg_pad[32*i +: 32];
        end
    end

    // Write channel: VALIDs and payload are registered on entry to WR and each
    // VALID falls on its own handshake, so READY never reaches VALID combinationally.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            idx_reg       <= 4'd0;
            retry_reg     <= 3'd0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            awaddr_reg    <= '0;
            wdata_reg     <= 32'd0;
            err_index_reg <= 4'd0;
            err_code_reg  <= 2'b00;
        end else begin
            idx_reg   <= idx_next;
            retry_reg <= retry_next;
            if (wr_entry) begin
                awvalid_reg <= 1'b1;
                wvalid_reg  <= 1'b1;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
                awaddr_reg  <= BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_next, 2'b00});
                // On the accepting edge the latch array is not yet loaded.
                wdata_reg   <= start_accept ? cfg_pad[31:0] : cfg_mem[idx_next];
            end else begin
                if (aw_hs) begin
                    awvalid_reg <= 1'b0;
                    aw_done_reg <= 1'b1;
                end
                if (w_hs) begin
                    wvalid_reg <= 1'b0;
                    w_done_reg <= 1'b1;
                end
            end
            if (start_accept) begin
                err_index_reg <= 4'd0;
                err_code_reg  <= 2'b00;
            end else if (fail && state_next == S_ERR) begin
                err_index_reg <= idx_reg;
                err_code_reg  <= fail_code;
            end
        end
    end

`ifdef ANTIGLITCH_CFG_READBACK_EN
    // Read channel: ARVALID registered on entry to RADDR, read data captured in RDATA.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arvalid_reg <= 1'b0;
            araddr_reg  <= '0;
            rdata_reg   <= 32'd0;
        end else begin
            if (state_next == S_RADDR && state_reg != S_RADDR) begin
                arvalid_reg <= 1'b1;
                araddr_reg  <= awaddr_reg;
            end else if (arvalid_reg && M_AXI_ARREADY) begin
                arvalid_reg <= 1'b0;
            end
            if (state_reg == S_RDATA && M_AXI_RVALID) rdata_reg <= M_AXI_RDATA;
        end
    end
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_RREADY  = (state_reg == S_RDATA);
`else
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_RREADY  = 1'b0;
`endif

    assign busy          = !(state_reg inside {S_IDLE, S_DONE, S_ERR});
    assign done          = (state_reg == S_DONE);
    assign err           = (state_reg == S_ERR);
    assign err_index     = err_index_reg;
    assign err_code      = err_code_reg;
    assign M_AXI_AWADDR  = awaddr_reg;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = (state_reg == S_WRESP);
    assign M_AXI_ARPROT  = 3'b000;

endmodule

// File: tb/tb_antiglitch_cfg_seq.sv
// Testbench for antiglitch_cfg_seq: an AXI4-Lite slave model with configurable
// READY latencies and fault injection, plus a register-level reference model
// of the write/readback/retry flow. Follows the ANTIGLITCH_CFG_READBACK_EN build.
module tb_antiglitch_cfg_seq;
    localparam int N  = 4;
    localparam int MR = 2;
`ifdef ANTIGLITCH_CFG_READBACK_EN
    localparam int PER_REG = 6;
`else
    localparam int PER_REG = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [N*32-1:0] cfg_data = '0;
    logic busy, done, err;
    logic [3:0] err_index;
    logic [1:0] err_code;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0] AWPROT, ARPROT;
    logic [3:0] WSTRB;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0] BRESP, RRESP;

    always #5 clk = ~clk;

    antiglitch_cfg_seq #(.NUM_REGS(N), .MAX_RETRY(MR)) dut (
        .ACLK(clk), .ARESET(rst), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .err(err), .err_index(err_index), .err_code(err_code),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    int checks = 0;
    int failures = 0;

    // Slave configuration and fault injection (count = number of faulty responses).
    int aw_lat, w_lat, ar_lat, b_lat, r_lat;
    bit rand_lat;
    int b_idx, b_cnt, r_idx, r_cnt, d_idx, d_cnt;
    int b_used, r_used, d_used;
    logic [31:0] smem [16];

    // Observed traffic and monitors.
    int wlog_addr[$];
    logic [31:0] wlog_data[$];
    int rlog_addr[$];
    int busy_cycles, aw_only, ar_seen, viol;

    // Reference model outcome.
    int exp_w[$];
    int exp_r[$];
    bit exp_done, exp_err;
    int exp_eidx, exp_ecode;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register-level model: each register is written (and read back when built),
    // a faulty response is retried up to MR times, then the sequence aborts.
    task automatic build_expect();
        int bu, retry, code;
`ifdef ANTIGLITCH_CFG_READBACK_EN
        int ru, du;
        ru = 0; du = 0;
`endif
        bu = 0;
        exp_w.delete(); exp_r.delete();
        exp_done = 0; exp_err = 0; exp_eidx = 0; exp_ecode = 0;
        for (int i = 0; i < N; i++) begin
            retry = 0;
            forever begin
                exp_w.push_back(i);
                code = 0;
                if (i == b_idx && bu < b_cnt) begin
                    bu++; code = 1;
                end
`ifdef ANTIGLITCH_CFG_READBACK_EN
                else begin
                    exp_r.push_back(i);
                    if (i == r_idx && ru < r_cnt) begin ru++; code = 2; end
                    else if (i == d_idx && du < d_cnt) begin du++; code = 3; end
                end
`endif
                if (code == 0) break;
                if (retry < MR) retry++;
                else begin
                    exp_err = 1; exp_eidx = i; exp_ecode = code;
                    return;
                end
            end
        end
        exp_done = 1;
    endtask

    // AXI4-Lite slave: samples handshakes on the rising edge, updates its
    // outputs 1 time unit later.
    initial begin
        bit s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
        bit aw_have, w_have, b_pend, r_pend, pend_aw, pend_w, pend_ar;
        logic [31:0] s_awaddr, s_wdata, s_araddr, aw_a, w_d, r_d;
        logic [1:0] b_code, r_code;
        int awc, wc, arc, bw, rw, ix;
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        pend_aw = 0; pend_w = 0; pend_ar = 0;
        awc = 0; wc = 0; arc = 0; bw = 0; rw = 0;
        aw_a = 0; w_d = 0; r_d = 0; b_code = 0; r_code = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = 0;
        forever begin
            @(posedge clk);
            s_aw_hs = AWVALID && AWREADY;
            s_w_hs  = WVALID && WREADY;
            s_b_hs  = BVALID && BREADY;
            s_ar_hs = ARVALID && ARREADY;
            s_r_hs  = RVALID && RREADY;
            s_awaddr = AWADDR; s_wdata = WDATA; s_araddr = ARADDR;
            if (busy) busy_cycles++;
            if (AWVALID && !WVALID) aw_only++;
            if (ARVALID) ar_seen++;
            if (!rst) begin
                if (pend_aw && !AWVALID) viol++;
                if (pend_w && !WVALID) viol++;
                if (pend_ar && !ARVALID) viol++;
                pend_aw = AWVALID && !AWREADY;
                pend_w  = WVALID && !WREADY;
                pend_ar = ARVALID && !ARREADY;
            end else begin
                pend_aw = 0; pend_w = 0; pend_ar = 0;
            end
            #1;
            if (rst) begin
                aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
                awc = 0; wc = 0; arc = 0;
                AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
                ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = 0;
                for (int i = 0; i < 16; i++) smem[i] = 0;
                continue;
            end
            if (s_aw_hs) begin aw_have = 1; aw_a = s_awaddr; if (rand_lat) aw_lat = $urandom_range(0, 3); end
            if (s_w_hs)  begin w_have = 1;  w_d = s_wdata;   if (rand_lat) w_lat = $urandom_range(0, 3); end
            if (s_b_hs) BVALID = 0;
            if (s_r_hs) RVALID = 0;
            if (aw_have && w_have) begin
                aw_have = 0; w_have = 0;
                ix = int'(aw_a[5:2]);
                smem[ix] = w_d;
                wlog_addr.push_back(int'(aw_a));
                wlog_data.push_back(w_d);
                b_code = 2'b00;
                if (ix == b_idx && b_used < b_cnt) begin b_used++; b_code = 2'b10; end
                b_pend = 1;
                bw = rand_lat ? $urandom_range(0, 2) : b_lat;
            end
            if (b_pend) begin
                if (bw == 0) begin BVALID = 1; BRESP = b_code; b_pend = 0; end
                else bw--;
            end
            if (s_ar_hs) begin
                if (rand_lat) ar_lat = $urandom_range(0, 3);
                ix = int'(s_araddr[5:2]);
                rlog_addr.push_back(int'(s_araddr));
                r_d = smem[ix];
                r_code = 2'b00;
                if (ix == r_idx && r_used < r_cnt) begin r_used++; r_code = 2'b10; end
                else if (ix == d_idx && d_used < d_cnt) begin
                    d_used++;
                    r_d = (r_d == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                end
                r_pend = 1;
                rw = rand_lat ? $urandom_range(0, 2) : r_lat;
            end
            if (r_pend) begin
                if (rw == 0) begin RVALID = 1; RRESP = r_code; RDATA = r_d; r_pend = 0; end
                else rw--;
            end
            // READY rises lat cycles after VALID is seen; lat 0 means held high.
            if (!AWVALID || aw_have) begin AWREADY = (aw_lat == 0) && !aw_have; awc = 0; end
            else if (awc >= aw_lat) AWREADY = 1;
            else begin awc++; AWREADY = 0; end
            if (!WVALID || w_have) begin WREADY = (w_lat == 0) && !w_have; wc = 0; end
            else if (wc >= w_lat) WREADY = 1;
            else begin wc++; WREADY = 0; end
            if (!ARVALID) begin ARREADY = (ar_lat == 0); arc = 0; end
            else if (arc >= ar_lat) ARREADY = 1;
            else begin arc++; ARREADY = 0; end
        end
    end

    task automatic clear_faults();
        b_idx = -1; b_cnt = 0; r_idx = -1; r_cnt = 0; d_idx = -1; d_cnt = 0;
        rand_lat = 0; aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
    endtask

    task automatic reset_check(input string tag);
        chk(tag, {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done, err,
                  err_index, err_code, AWADDR, WDATA, ARADDR}, 128'd0);
    endtask

    // One configuration sequence followed by outcome and traffic comparisons.
    task automatic run_seq(input logic [N*32-1:0] cfg_v, input bit disturb, input string tag);
        bit fin;
        int sz;
        build_expect();
        wlog_addr.delete(); wlog_data.delete(); rlog_addr.delete();
        b_used = 0; r_used = 0; d_used = 0;
        @(posedge clk); #1;
        busy_cycles = 0; aw_only = 0; ar_seen = 0;
        cfg_data = cfg_v; start = 1;
        @(posedge clk); #1;
        start = 0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_prot_strb"}, {AWPROT, ARPROT, WSTRB}, 10'h00F);
        fin = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (disturb && c == 4) begin cfg_data = ~cfg_v; start = 1; end
            else if (disturb && c == 5) start = 0;
            @(posedge clk); #1;
            if (done || err) fin = 1;
        end
        start = 0;
        chk({tag, "_finished"}, fin, 1'b1);
        chk({tag, "_outcome"}, {busy, done, err, err_index, err_code},
            {1'b0, exp_done, exp_err, 4'(exp_eidx), 2'(exp_ecode)});
        chk({tag, "_nwrites"}, wlog_addr.size(), exp_w.size());
        sz = exp_w.size();
        for (int k = 0; k < sz; k++) begin
            chk({tag, "_waddr"}, (k < wlog_addr.size()) ? 32'(wlog_addr[k]) : 32'hxxxx_xxxx, 32'(4 * exp_w[k]));
            chk({tag, "_wdata"}, (k < wlog_data.size()) ? wlog_data[k] : 32'hxxxx_xxxx, cfg_v[32*exp_w[k] +: 32]);
        end
        chk({tag, "_nreads"}, rlog_addr.size(), exp_r.size());
        sz = exp_r.size();
        for (int k = 0; k < sz; k++)
            chk({tag, "_raddr"}, (k < rlog_addr.size()) ? 32'(rlog_addr[k]) : 32'hxxxx_xxxx, 32'(4 * exp_r[k]));
        if (exp_done)
            for (int i = 0; i < N; i++) chk({tag, "_slave_reg"}, smem[i], cfg_v[32*i +: 32]);
        $display("seq %s: writes=%0d reads=%0d done=%0b err=%0b idx=%0d code=%0d",
                 tag, wlog_addr.size(), rlog_addr.size(), done, err, err_index, err_code);
    endtask

    initial begin
        logic [N*32-1:0] cfg1, cfg_r;
        bit hit;
        int kind;
        clear_faults();
        cfg1 = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};

        // Power-on reset.
        #1 rst = 1;
        #1 reset_check("reset_state");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // 1: always-ready slave, nominal per-register cost.
        run_seq(cfg1, 0, "t1_ready");
        chk("t1_busy_cycles", busy_cycles, PER_REG * N);
`ifdef ANTIGLITCH_CFG_READBACK_EN
        chk("t1_ar_cycles", ar_seen, N);
`endif

        // 2: AWREADY delayed 3 cycles, WREADY immediate.
        aw_lat = 3;
        run_seq(cfg1 ^ {N{32'h1357_9bdf}}, 0, "t2_aw_delay");
        chk("t2_aw_only_cycles", aw_only, 3 * exp_w.size());
        clear_faults();

        // 3: persistent bad BRESP on register 2.
        b_idx = 2; b_cnt = 99;
        run_seq(cfg1, 0, "t3_bresp");
        chk("t3_err_fields", {err, err_index, err_code}, {1'b1, 4'd2, 2'b01});
        clear_faults();

`ifdef ANTIGLITCH_CFG_READBACK_EN
        // 4: first readback of register 1 corrupted.
        d_idx = 1; d_cnt = 1;
        run_seq(cfg1, 0, "t4_corrupt");
        clear_faults();
`endif

        // 5: asynchronous reset in the middle of register 1.
        @(posedge clk); #1;
        cfg_data = cfg1; start = 1;
        @(posedge clk); #1;
        start = 0;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
`ifdef ANTIGLITCH_CFG_READBACK_EN
            if (RREADY && ARADDR == 32'h4) hit = 1;
`else
            if (BREADY && AWADDR == 32'h4) hit = 1;
`endif
            if (!hit) begin @(posedge clk); #1; end
        end
        chk("t5_reached_idx1", hit, 1'b1);
        #2 rst = 1;
        #1 reset_check("t5_async_reset");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        run_seq(~cfg1, 0, "t5_after_reset");

        // 6: start while busy and cfg_data changed mid-sequence.
        run_seq(cfg1 ^ {N{32'h00ff_0f0f}}, 1, "t6_restart_ignored");
`ifndef ANTIGLITCH_CFG_READBACK_EN
        chk("t6_no_arvalid", ar_seen, 0);
`endif

        // Randomised sequences: random data, latencies and one fault type.
        for (int it = 0; it < 8; it++) begin
            clear_faults();
            rand_lat = 1;
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
            for (int i = 0; i < N; i++) cfg_r[32*i +: 32] = $urandom;
            kind = $urandom_range(0, 3);
            if (kind == 1) begin b_idx = $urandom_range(0, N - 1); b_cnt = $urandom_range(1, 4); end
            if (kind == 2) begin r_idx = $urandom_range(0, N - 1); r_cnt = $urandom_range(1, 4); end
            if (kind == 3) begin d_idx = $urandom_range(0, N - 1); d_cnt = $urandom_range(1, 4); end
            run_seq(cfg_r, it[0], $sformatf("rand%0d", it));
        end

        chk("axi_valid_held", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/antiglitch_cfg_seq.md
Name: antiglitch_cfg_seq

Overview:
- AXI4-Lite master sequencer that configures the antiglitch slave register bank after reset or on request.
- For each of NUM_REGS registers it writes a value, reads it back, and compares. A failing register is retried up to MAX_RETRY times.
- Sits between the system control logic (start/status) and the antiglitch S00_AXI slave port. It replaces the BFM-driven write/read/compare sequence used in simulation.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32).
- BASE_ADDR, 32'h0000_0000, address of register 0; register i is at BASE_ADDR + 4*i.
- NUM_REGS, 4, number of registers to configure (1..16).
- MAX_RETRY, 2, retries per register after the first failed attempt (0..7).

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESET  in  1  asynchronous active-high reset.
- start  in  1  pulse that launches a configuration sequence.
- cfg_data  in  NUM_REGS*32  register values, reg i at bits [32*i+31:32*i].
- busy  out  1  sequence in progress.
- done  out  1  level; last sequence finished successfully.
- err  out  1  level; last sequence aborted.
- err_index  out  4  register index that failed.
- err_code  out  2  01 = bad BRESP, 10 = bad RRESP, 11 = data mismatch.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  ADDR/3/1/1  write address channel.
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel.
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  ADDR/3/1/1  read address channel.
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel.

Behaviour:
- Reset (ARESET=1, asynchronous): state IDLE. All VALID/READY outputs 0. busy, done, err = 0; err_index, err_code = 0; AXI address/data outputs 0.
- Reset mid-transaction abandons the transfer. The slave is reset by the same system reset.
- AWPROT and ARPROT are always 0. WSTRB is always 4'hF.
- cfg_data is latched into an internal array on the accepted start; later changes to cfg_data are ignored.
- start is accepted only in IDLE, DONE or ERR; it is ignored while busy. Acceptance clears done, err, err_index and err_code, sets busy, and sets idx=0, retry=0.
- FSM states and transitions:
  - IDLE: wait for start.
  - WR: AWVALID and WVALID are asserted together the cycle after entry. Each is dropped independently on its own handshake (VALID&READY). Go to WRESP when both handshakes are done, in either order or the same cycle.
  - WRESP: BREADY=1. On BVALID, BRESP must be 00; otherwise fail with code 01. Then go to RADDR.
  - RADDR: ARVALID=1 until ARREADY, then go to RDATA.
  - RDATA: RREADY=1. On RVALID, capture RDATA/RRESP. RRESP must be 00, otherwise fail with code 10. Then go to CHECK.
  - CHECK: if the captured data equals the latched value, go to NEXT; otherwise fail with code 11.
  - NEXT: idx+1 and retry=0. If idx was NUM_REGS-1, go to DONE; otherwise go to WR.
  - Fail handling: if retry < MAX_RETRY, retry+1 and go back to WR for the same idx. Otherwise go to ERR with err_index=idx and err_code latched.
  - DONE: done=1, busy=0. ERR: err=1, busy=0. Both hold until the next start.
- VALID is never dropped before its handshake. No combinational path from any READY to any VALID output.
- Minimum occupancy is 1 cycle per state. Against a slave holding READY high with 1-cycle BVALID/RVALID, one register costs 6 cycles.
- err_index width 4 covers NUM_REGS up to 16.

Optional Feature:
- Macro: ANTIGLITCH_CFG_READBACK_EN.
- Defined: full write/readback/compare flow as described above.
- Undefined:
  - WRESP goes directly to NEXT; RADDR, RDATA and CHECK are not built.
  - ARVALID and RREADY are tied 0; ARADDR is tied 0.
  - err_code values 10 and 11 never occur; retries apply to bad BRESP only.

Test Plan:
1. Slave always ready; cfg_data = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF}; start -> writes then reads at 0x0, 0x4, 0x8, 0xC in order; done=1, err=0, busy=0; slave registers hold those values.
2. Slave delays AWREADY 3 cycles and WREADY 0 cycles -> WVALID drops after 1 cycle while AWVALID stays high until its handshake; exactly one write per register.
3. Slave returns BRESP=2'b10 on every write to 0x8 with MAX_RETRY=2 -> three write attempts at 0x8, then err=1, err_index=2, err_code=01; 0xC is never accessed.
4. Slave corrupts the first readback of 0x4 only (returns 0) -> one retry at 0x4, then the sequence completes with done=1.
5. Assert ARESET while in RDATA for idx=1 -> all outputs 0 immediately without waiting for a clock; a new start after reset reruns from idx=0 and completes.
6. start pulsed while busy, and cfg_data changed mid-sequence -> no restart; the originally latched values are written. Build without ANTIGLITCH_CFG_READBACK_EN -> ARVALID never asserted, done=1.
